// File: rtl/uart_send_frame_if.sv
// Frame-request / status / serial-line bundle for uart_send_frame.
// The master side requests frames; the slave side is the transmitter.
interface uart_send_frame_if #(
  parameter int NBYTES = 8
);
  logic                  start;
  logic [8*NBYTES-1:0]   din;
  logic                  busy;
  logic                  done;
  logic [4:0]            byte_idx;
  logic                  uart_txd;

  modport master (
    output start, din,
    input  busy, done, byte_idx, uart_txd
  );

  modport slave (
    input  start, din,
    output busy, done, byte_idx, uart_txd
  );
endinterface

// File: rtl/uart_send_frame.sv
// Multi-byte UART frame transmitter: 8N1 per byte, back-to-back bytes,
// optional modulo-256 checksum byte appended after the payload.
module uart_send_frame #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 9600,
  parameter int NBYTES     = 8,
  parameter int MSB_FIRST  = 0,
  parameter int ADD_CHKSUM = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  uart_send_frame_if.slave bus
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);
  localparam logic [4:0]    LAST_IDX  = 5'(NBYTES - 1 + ADD_CHKSUM);
  localparam logic [4:0]    NB5       = 5'(NBYTES);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       baud_reg, baud_next;
  logic [2:0]          bit_reg, bit_next;
  logic [4:0]          idx_reg, idx_next;
  logic [8*NBYTES-1:0] payload_reg, payload_next;
  logic [7:0]          chk_reg, chk_next;
  logic                txd_reg, txd_next;
  logic                done_reg, done_next;

  // Byte lanes in transmission order; the slot after the payload carries the checksum.
  logic [7:0] lane [0:NBYTES];
  logic [7:0] cur_byte;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    if (MSB_FIRST != 0) begin : g_msb
      assign lane[gi] = payload_reg[8*(NBYTES-1-gi) +: 8];
    end else begin : g_lsb
      assign lane[gi] = payload_reg[8*gi +: 8];
    end
  end
  assign lane[NBYTES] = chk_reg;

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i <= NBYTES; i++) begin
      if (idx_reg == 5'(i)) cur_byte = lane[i];
    end
  end

  // txd_next is the level for the state being entered, so the line stays registered.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_next     = bit_reg;
    idx_next     = idx_reg;
    payload_next = payload_reg;
    chk_next     = chk_reg;
    txd_next     = txd_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        idx_next = 5'd0;
        if (bus.start) begin
          state_next   = START_BIT;
          payload_next = bus.din;
          chk_next     = 8'h00;
          baud_next    = '0;
          bit_next     = 3'd0;
          txd_next     = 1'b0;
        end
      end
      START_BIT: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA_BITS;
          txd_next   = cur_byte[0];
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA_BITS: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP_BIT;
            txd_next   = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
            txd_next = cur_byte[bit_reg + 3'd1];
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (idx_reg < NB5) chk_next = chk_reg + cur_byte;
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
            idx_next   = 5'd0;
            txd_next   = 1'b1;
          end else begin
            state_next = START_BIT;
            idx_next   = idx_reg + 5'd1;
            txd_next   = 1'b0;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_reg     <= 3'd0;
      idx_reg     <= 5'd0;
      payload_reg <= '0;
      chk_reg     <= 8'h00;
      txd_reg     <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      idx_reg     <= idx_next;
      payload_reg <= payload_next;
      chk_reg     <= chk_next;
      txd_reg     <= txd_next;
      done_reg    <= done_next;
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.byte_idx = idx_reg;
  assign bus.uart_txd = txd_reg;
endmodule

// File: tb/tb_uart_send_frame.sv
// Directed bench: four transmitter configurations, a byte scoreboard fed at
// stimulus time, and a mid-bit line decoder that pops and compares.
module tb_uart_send_frame;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [63:0] din_v;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_send_frame_if #(.NBYTES(8)) if0 ();
  uart_send_frame_if #(.NBYTES(8)) if1 ();
  uart_send_frame_if #(.NBYTES(8)) if2 ();
  uart_send_frame_if #(.NBYTES(1)) if3 ();

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];
  assign if0.din   = din_v;
  assign if1.din   = din_v;
  assign if2.din   = din_v;
  assign if3.din   = din_v[7:0];

  uart_send_frame #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(8), .MSB_FIRST(0), .ADD_CHKSUM(1))
    u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if0));
  uart_send_frame #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(8), .MSB_FIRST(1), .ADD_CHKSUM(1))
    u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));
  uart_send_frame #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(8), .MSB_FIRST(0), .ADD_CHKSUM(0))
    u2 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if2));
  uart_send_frame #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(1), .MSB_FIRST(0), .ADD_CHKSUM(0))
    u3 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if3));

  logic       txd_m, busy_m, done_m;
  logic [4:0] idx_m;

  always_comb begin
    txd_m  = if0.uart_txd;
    busy_m = if0.busy;
    done_m = if0.done;
    idx_m  = if0.byte_idx;
    case (sel)
      1: begin txd_m = if1.uart_txd; busy_m = if1.busy; done_m = if1.done; idx_m = if1.byte_idx; end
      2: begin txd_m = if2.uart_txd; busy_m = if2.busy; done_m = if2.done; idx_m = if2.byte_idx; end
      3: begin txd_m = if3.uart_txd; busy_m = if3.busy; done_m = if3.done; idx_m = if3.byte_idx; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [7:0] b;
    logic [4:0] idx;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [63:0] d, input int nb, input int msb, input int addchk);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = (msb != 0) ? d[8*(nb-1-i) +: 8] : d[8*i +: 8];
      exp_q.push_back({b, 5'(i)});
      sum = sum + b;
    end
    if (addchk != 0) exp_q.push_back({sum, 5'(nb)});
  endtask

  task automatic pulse(input int s);
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // Entered on a negedge; returns on the negedge of the done cycle.
  task automatic rx_frame(input int ntot, input string tag, output int waited);
    exp_t       e;
    logic [7:0] rx;
    waited = 0;
    while (txd_m !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ".first_low"}, {31'd0, txd_m}, 32'd0);
    for (int n = 0; n < ntot; n++) begin
      repeat (5) @(negedge clk);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else check({tag, ".queue_empty"}, 32'd0, 32'd1);
      check($sformatf("%s.b%0d.start", tag, n), {31'd0, txd_m}, 32'd0);
      check($sformatf("%s.b%0d.idx", tag, n), {27'd0, idx_m}, {27'd0, e.idx});
      for (int k = 0; k < 8; k++) begin
        repeat (10) @(negedge clk);
        rx[k] = txd_m;
      end
      repeat (10) @(negedge clk);
      check($sformatf("%s.b%0d.stop", tag, n), {31'd0, txd_m}, 32'd1);
      check($sformatf("%s.b%0d.data", tag, n), {24'd0, rx}, {24'd0, e.b});
      repeat (4) @(negedge clk);
      if (n == ntot - 1) begin
        check({tag, ".last_stop_busy"}, {31'd0, busy_m}, 32'd1);
        check({tag, ".last_stop_done"}, {31'd0, done_m}, 32'd0);
      end
      @(negedge clk);
    end
    check({tag, ".done"}, {31'd0, done_m}, 32'd1);
    check({tag, ".busy_end"}, {31'd0, busy_m}, 32'd0);
    check({tag, ".txd_end"}, {31'd0, txd_m}, 32'd1);
    check({tag, ".idx_end"}, {27'd0, idx_m}, 32'd0);
  endtask

  initial begin
    int w1, w2, lows;
    rst_n   = 1'b0;
    start_v = 4'b0000;
    din_v   = 64'h0;
    sel     = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check($sformatf("rst%0d.txd", s), {31'd0, txd_m}, 32'd1);
      check($sformatf("rst%0d.busy", s), {31'd0, busy_m}, 32'd0);
      check($sformatf("rst%0d.done", s), {31'd0, done_m}, 32'd0);
      check($sformatf("rst%0d.idx", s), {27'd0, idx_m}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LSB-first payload with checksum 0x24
    sel = 0;
    din_v = 64'h0807060504030201;
    push_frame(din_v, 8, 0, 1);
    pulse(0);
    rx_frame(9, "lsb", w1);
    check("lsb.latency", w1, 0);

    // MSB-first ordering
    sel = 1;
    push_frame(din_v, 8, 1, 1);
    pulse(1);
    rx_frame(9, "msb", w1);
    check("msb.latency", w1, 0);

    // checksum wraps: 8 x 0xFF -> 0xF8
    sel = 0;
    din_v = 64'hFFFF_FFFF_FFFF_FFFF;
    push_frame(din_v, 8, 0, 1);
    pulse(0);
    rx_frame(9, "ff", w1);

    // no checksum: 800-cycle frame
    sel = 2;
    din_v = 64'h0807060504030201;
    push_frame(din_v, 8, 0, 0);
    pulse(2);
    rx_frame(8, "nochk", w1);

    // single byte 0xA5, 100-cycle frame
    sel = 3;
    din_v = 64'h00000000000000A5;
    push_frame(din_v, 1, 0, 0);
    pulse(3);
    rx_frame(1, "one", w1);

    // held start: back-to-back frames, din changes mid-frame only affect the next one
    sel = 0;
    din_v = 64'h1357_9BDF_0246_8ACE;
    push_frame(din_v, 8, 0, 1);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    fork
      begin
        rx_frame(9, "held1", w1);
        rx_frame(9, "held2", w2);
      end
      begin
        repeat (400) @(negedge clk);
        din_v = 64'hDEAD_BEEF_CAFE_F00D;
        push_frame(din_v, 8, 0, 1);
        repeat (1000) @(negedge clk);
        start_v[0] = 1'b0;
      end
    join
    check("held1.latency", w1, 0);
    check("held2.gap", w2, 1);
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd_m !== 1'b1 || busy_m !== 1'b0) lows++;
    end
    check("held.idle_after", lows, 0);

    // reset during byte 3 data bits aborts immediately
    din_v = 64'h1122_3344_5566_7788;
    pulse(0);
    repeat (335) @(negedge clk);
    check("abort.idx_before", {27'd0, idx_m}, 32'd3);
    check("abort.busy_before", {31'd0, busy_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.txd", {31'd0, txd_m}, 32'd1);
    check("abort.busy", {31'd0, busy_m}, 32'd0);
    check("abort.done", {31'd0, done_m}, 32'd0);
    check("abort.idx", {27'd0, idx_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd_m !== 1'b1 || busy_m !== 1'b0) lows++;
    end
    check("abort.idle_after", lows, 0);
    check("queue.drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_send_frame.md
UART_SEND_FRAME -- requirements
Module: uart_send_frame

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, baud rate.
REQ-003 SHALL have parameter NBYTES, default 8, range 1..16, payload bytes per frame.
REQ-004 SHALL have parameter MSB_FIRST, default 0; 0 = byte 0 is din[7:0] and is sent first; 1 = din[8*NBYTES-1 -: 8] is sent first.
REQ-005 SHALL have parameter ADD_CHKSUM, default 1; 1 = one checksum byte is appended after the payload.
REQ-006 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port start  input  1  frame request, level-sampled.
REQ-009 SHALL have port din  input  8*NBYTES  payload.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port byte_idx  output  5  index of the byte currently on the line (0-based, checksum = NBYTES).
REQ-013 SHALL have port uart_txd  output  1  serial line, registered.

Function
REQ-014 SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer division) clock cycles per bit.
REQ-015 SHALL implement FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT.
REQ-016 In IDLE with start=1, SHALL latch din and clear the checksum accumulator, then enter START_BIT; busy=1 and uart_txd=0 from the next cycle.
REQ-017 start SHALL be ignored while busy=1; a held start SHALL NOT retrigger until the cycle after done.
REQ-018 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1); each bit SHALL be exactly BPS_CNT cycles.
REQ-019 START_BIT -> DATA_BITS after BPS_CNT cycles; DATA_BITS -> STOP_BIT after 8*BPS_CNT cycles; STOP_BIT -> START_BIT of the next byte with no idle gap, or -> IDLE after the last byte.
REQ-020 Byte order SHALL follow MSB_FIRST; byte_idx SHALL increment at each stop-to-start transition.
REQ-021 Checksum SHALL be the 8-bit modulo-256 sum of all NBYTES payload bytes, sent as byte NBYTES when ADD_CHKSUM=1.
REQ-022 Frame length SHALL be (NBYTES+ADD_CHKSUM)*10*BPS_CNT cycles, measured from the first uart_txd low to the last stop-bit cycle inclusive.
REQ-023 On the cycle after the last stop-bit cycle, done SHALL be 1 for one cycle, busy SHALL be 0, and uart_txd SHALL be 1.
REQ-024 start=1 in the cycle where done=1 SHALL be accepted; back-to-back frames then have zero idle bit time.
REQ-025 Changes on din while busy SHALL NOT affect the frame in progress.
REQ-026 byte_idx SHALL be 0 in IDLE.

Reset
REQ-027 With sys_rst_n=0, SHALL immediately force state=IDLE, uart_txd=1, busy=0, done=0, byte_idx=0, and clear the bit counter, baud counter and checksum.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the next frame after reset release SHALL start only on a new start sample.

Verification
REQ-029 Use CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10), NBYTES=8, MSB_FIRST=0, ADD_CHKSUM=1; din=0x0807060504030201, pulse start -> line decodes bytes 01..08 then 0x24; done exactly 900 cycles after the first txd low.
REQ-030 Same din with MSB_FIRST=1 -> bytes 08,07,...,01 then 0x24; byte_idx steps 0..8.
REQ-031 ADD_CHKSUM=1, all payload bytes 0xFF -> checksum byte 0xF8 (wraps modulo 256); ADD_CHKSUM=0 -> 8 bytes only, done after 800 cycles.
REQ-032 Hold start=1 continuously -> frames repeat with the next start bit in the cycle after done; din changed mid-frame -> current frame unchanged.
REQ-033 Assert sys_rst_n=0 during byte 3 data bits -> uart_txd=1, busy=0 immediately; after release with start=0 the line stays idle high.
REQ-034 NBYTES=1, ADD_CHKSUM=0, din=0xA5 -> exactly one 10-bit frame 0,1,0,1,0,0,1,0,1,1; done after 100 cycles.
